// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out word serializer with a
// valid/ready load handshake and a strobe for a downstream SIPO stage.
//
// Parameters:
//   SIZE - word width in bits (>= 2)
//   DIV  - clock cycles per serial bit (>= 1)
//
// Ports:
//   clk        - single clock, all state on its rising edge
//   reset      - synchronous active-high reset
//   load_valid - upstream presents a word on p_in
//   load_ready - block accepts a word this cycle (high only in IDLE)
//   p_in       - parallel word to serialize
//   shift      - one-cycle strobe: downstream captures s_out
//   s_out      - serial data, MSB first (0 outside SHIFT)
//   busy       - word in flight (SHIFT or DONE)
//   done       - one-cycle pulse after the last bit is strobed
module piso_serializer #(
  parameter int SIZE = 256,
  parameter int DIV  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [SIZE-1:0] p_in,
  output logic            shift,
  output logic            s_out,
  output logic            busy,
  output logic            done
);

  localparam int CNT_W = $clog2(SIZE + 1);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [SIZE-1:0]   r_sreg;
  logic [CNT_W-1:0]  r_bitcnt;
  logic [DIV_W-1:0]  r_divcnt;

  logic w_load;
  logic w_tick;
  logic w_last;

  // Bit strobe fires on the final divider count of each bit period.
  always_comb begin
    w_load = (r_state == S_IDLE) && load_valid;
    w_tick = (r_state == S_SHIFT) && (r_divcnt == DIV_W'(DIV - 1));
    w_last = w_tick && (r_bitcnt == CNT_W'(SIZE - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    load_ready = 1'b0;
    shift      = 1'b0;
    s_out      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        load_ready = 1'b1;
        if (w_load) begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy  = 1'b1;
        shift = w_tick;
        s_out = r_sreg[SIZE-1];
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sreg   <= '0;
      r_bitcnt <= '0;
      r_divcnt <= '0;
    end else if (w_load) begin
      r_sreg   <= p_in;
      r_bitcnt <= '0;
      r_divcnt <= '0;
    end else if (r_state == S_SHIFT) begin
      if (w_tick) begin
        r_sreg   <= {r_sreg[SIZE-2:0], 1'b0};
        r_bitcnt <= r_bitcnt + 1'b1;
        r_divcnt <= '0;
      end else begin
        r_divcnt <= r_divcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed testbench for piso_serializer (SIZE=8). Two instances are
// built, DIV=1 and DIV=3; 'sel' routes the shared stimulus to one of them
// and muxes its outputs back. A behavioural SIPO stage listens to the
// selected instance for the loopback phase.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       lv;
  logic [7:0] p_in;
  logic       sel;

  logic lv1, lv3;
  logic rdy1, sh1, so1, bsy1, dn1;
  logic rdy3, sh3, so3, bsy3, dn3;
  logic w_ready, w_shift, w_sout, w_busy, w_done;

  logic [7:0] r_sipo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign lv1     = lv & ~sel;
  assign lv3     = lv &  sel;
  assign w_ready = sel ? rdy3 : rdy1;
  assign w_shift = sel ? sh3  : sh1;
  assign w_sout  = sel ? so3  : so1;
  assign w_busy  = sel ? bsy3 : bsy1;
  assign w_done  = sel ? dn3  : dn1;

  piso_serializer #(.SIZE(8), .DIV(1)) u_d1 (
    .clk        (clk),
    .reset      (reset),
    .load_valid (lv1),
    .load_ready (rdy1),
    .p_in       (p_in),
    .shift      (sh1),
    .s_out      (so1),
    .busy       (bsy1),
    .done       (dn1)
  );

  piso_serializer #(.SIZE(8), .DIV(3)) u_d3 (
    .clk        (clk),
    .reset      (reset),
    .load_valid (lv3),
    .load_ready (rdy3),
    .p_in       (p_in),
    .shift      (sh3),
    .s_out      (so3),
    .busy       (bsy3),
    .done       (dn3)
  );

  // Downstream SIPO: captures s_out MSB-first on each strobe.
  always @(posedge clk) begin
    if (reset) r_sipo <= '0;
    else if (w_shift) r_sipo <= {r_sipo[6:0], w_sout};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, w_ready, 1);
    chk({tag, "_shift"}, w_shift, 0);
    chk({tag, "_sout"},  w_sout,  0);
    chk({tag, "_busy"},  w_busy,  0);
    chk({tag, "_done"},  w_done,  0);
  endtask

  // Called in a cycle where the selected instance is idle. With hold=1,
  // load_valid stays high and p_in carries junk while the word is in flight.
  task automatic run_word(input logic [7:0] w, input int div, input bit hold);
    logic [7:0] wv;
    wv   = w;
    lv   = 1'b1;
    p_in = w;
    chk("hs_ready", w_ready, 1);
    tick;
    if (!hold) lv = 1'b0;
    for (int c = 1; c <= 8 * div; c++) begin
      if (hold) p_in = ~w ^ 8'(c);
      chk("shift", w_shift, ((c % div) == 0) ? 1 : 0);
      chk("s_out", w_sout, wv[7 - (c - 1) / div]);
      chk("busy",  w_busy, 1);
      chk("ready", w_ready, 0);
      chk("done_early", w_done, 0);
      tick;
    end
    if (hold) p_in = ~w;
    chk("done",       w_done,  1);
    chk("done_busy",  w_busy,  1);
    chk("done_shift", w_shift, 0);
    chk("done_sout",  w_sout,  0);
    chk("done_ready", w_ready, 0);
    tick;
    chk("post_ready", w_ready, 1);
    chk("post_done",  w_done,  0);
    chk("post_busy",  w_busy,  0);
    chk("post_shift", w_shift, 0);
  endtask

  initial begin
    logic [7:0] w;
    int         pulses;
    bit         seen;

    reset = 1'b1;
    lv    = 1'b0;
    p_in  = '0;
    sel   = 1'b0;
    tick;
    tick;
    chk_idle("rst_d1");
    sel = 1'b1;
    chk_idle("rst_d3");
    reset = 1'b0;
    tick;
    chk_idle("rel_d3");
    sel = 1'b0;
    chk_idle("rel_d1");

    // Single word, DIV=1
    run_word(8'hA5, 1, 1'b0);

    // Single word, DIV=3
    sel = 1'b1;
    run_word(8'h81, 3, 1'b0);
    sel = 1'b0;

    // Back-to-back with load_valid held and p_in churning
    run_word(8'h5A, 1, 1'b1);
    run_word(8'hC3, 1, 1'b0);

    // Reset in the middle of a word
    lv   = 1'b1;
    p_in = 8'hF0;
    tick;                // T0+1
    lv = 1'b0;
    tick;                // T0+2
    tick;                // T0+3
    tick;                // T0+4
    reset = 1'b1;
    tick;                // T0+5
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_idle("abort");
      tick;
    end
    run_word(8'h3C, 1, 1'b0);

    // Reset wins over a simultaneous handshake
    reset = 1'b1;
    lv    = 1'b1;
    p_in  = 8'hFF;
    tick;
    reset = 1'b0;
    lv    = 1'b0;
    chk_idle("rst_prio");
    tick;
    chk_idle("rst_prio2");

    // Loopback into the SIPO model across both divider settings
    for (int n = 0; n < 1000; n++) begin
      sel  = 1'($urandom_range(0, 1));
      w    = 8'($urandom);
      lv   = 1'b1;
      p_in = w;
      tick;
      lv     = 1'b0;
      pulses = 0;
      seen   = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        if (w_done) seen = 1'b1;
        else begin
          if (w_shift) pulses++;
          tick;
        end
      end
      chk("loop_done",   seen,   1);
      chk("loop_pulses", pulses, 8);
      chk("loop_word",   r_sipo, w);
      tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
